// File: rtl/simple_bus_mux.sv
`default_nettype none
// ============================================================================
// Module   : simple_bus_mux
// Brief    : Registered single-master to NUM_SLAVES bus multiplexer with
//            address decode, per-access ready handshake, timeout, error
//            response and saturating error counter.
// Revision : 1.0 - initial release
// ============================================================================
module simple_bus_mux #(
   parameter int                         NUM_SLAVES = 4,
   parameter int                         ADDR_W     = 32,
   parameter int                         DATA_W     = 32,
   parameter int                         SEL_W      = 16,
   parameter logic [NUM_SLAVES*SEL_W-1:0] SLAVE_BASE =
      {16'h4000, 16'h3000, 16'h2000, 16'h1000},
   parameter int                         TIMEOUT    = 16
) (
   input  logic                         clk,
   input  logic                         rst,          // asynchronous, active-low
   input  logic [ADDR_W-1:0]            i_m_addr,
   input  logic [DATA_W-1:0]            i_m_wdata,
   input  logic                         i_m_we,
   input  logic                         i_m_re,
   output logic [DATA_W-1:0]            o_m_rdata,
   output logic                         o_m_ready,
   output logic                         o_m_err,
   output logic [7:0]                   o_err_count,
   output logic [ADDR_W-1:0]            o_s_addr,
   output logic [DATA_W-1:0]            o_s_wdata,
   output logic [NUM_SLAVES-1:0]        o_s_we,
   output logic [NUM_SLAVES-1:0]        o_s_re,
   input  logic [NUM_SLAVES*DATA_W-1:0] i_s_rdata,
   input  logic [NUM_SLAVES-1:0]        i_s_ready
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_we_op;
   logic [IDX_W-1:0]    r_idx;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_err;
   logic [7:0]          r_err_count;

   logic                w_req;
   logic [SEL_W-1:0]    w_sel;
   logic                w_hit;
   logic [IDX_W-1:0]    w_idx;
   logic                w_ready_sel;
   logic [DATA_W-1:0]   w_rdata_sel;
   logic                w_timeout;
   logic [NUM_SLAVES-1:0] w_onehot;
   logic                w_in_access;
   logic                w_in_resp;

   assign w_req       = i_m_we | i_m_re;
   assign w_sel       = i_m_addr[ADDR_W-1 -: SEL_W];
   assign w_ready_sel = i_s_ready[r_idx];
   assign w_rdata_sel = i_s_rdata[r_idx*DATA_W +: DATA_W];
   assign w_timeout   = (r_cnt == C_CNT_LAST);
   assign w_onehot    = NUM_SLAVES'(1) << r_idx;
   assign w_in_access = (r_state == ST_ACCESS);
   assign w_in_resp   = (r_state == ST_RESP);

   // Address decode: scan from the top so the lowest matching index wins
   always_comb begin
      w_hit = 1'b0;
      w_idx = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (w_sel == SLAVE_BASE[i*SEL_W +: SEL_W]) begin
            w_hit = 1'b1;
            w_idx = IDX_W'(i);
         end
      end
   end

   // State register; reset aborts any transaction in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; ready takes priority over the timeout
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               w_state_nxt = w_hit ? ST_ACCESS : ST_RESP;
            end
         end
         ST_ACCESS: begin
            if (w_ready_sel || w_timeout) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Transaction datapath: latch request, count wait cycles, capture response
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_we_op <= 1'b0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  if (w_hit) begin
                     r_addr  <= i_m_addr;
                     r_wdata <= i_m_wdata;
                     r_we_op <= i_m_we;   // write wins when both are requested
                     r_idx   <= w_idx;
                     r_cnt   <= '0;
                  end else begin
                     r_err   <= 1'b1;
                     r_rdata <= '0;
                  end
               end
            end
            ST_ACCESS: begin
               if (w_ready_sel) begin
                  r_err   <= 1'b0;
                  r_rdata <= r_we_op ? '0 : w_rdata_sel;
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
               end else begin
                  r_cnt   <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Saturating count of error responses, bumped once per erroring RESP
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err_count <= '0;
      end else if (w_in_resp && r_err && (r_err_count != 8'hFF)) begin
         r_err_count <= r_err_count + 8'd1;
      end
   end

   assign o_s_we      = (w_in_access &&  r_we_op) ? w_onehot : '0;
   assign o_s_re      = (w_in_access && !r_we_op) ? w_onehot : '0;
   assign o_s_addr    = w_in_access ? r_addr  : '0;
   assign o_s_wdata   = w_in_access ? r_wdata : '0;
   assign o_m_ready   = w_in_resp;
   assign o_m_err     = w_in_resp & r_err;
   assign o_m_rdata   = w_in_resp ? r_rdata : '0;
   assign o_err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_simple_bus_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_bus_mux
// Brief    : Scoreboard bench for simple_bus_mux: directed cases plus random
//            transactions against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simple_bus_mux;

   localparam int NS = 4;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [31:0]   m_addr = '0;
   logic [31:0]   m_wdata = '0;
   logic          m_we = 1'b0;
   logic          m_re = 1'b0;
   logic [31:0]   m_rdata;
   logic          m_ready;
   logic          m_err;
   logic [7:0]    err_count;
   logic [31:0]   s_addr;
   logic [31:0]   s_wdata;
   logic [NS-1:0] s_we;
   logic [NS-1:0] s_re;
   logic [NS*32-1:0] s_rdata = '0;
   logic [NS-1:0] s_ready = '0;

   simple_bus_mux dut (
      .clk         (clk),
      .rst         (rst),
      .i_m_addr    (m_addr),
      .i_m_wdata   (m_wdata),
      .i_m_we      (m_we),
      .i_m_re      (m_re),
      .o_m_rdata   (m_rdata),
      .o_m_ready   (m_ready),
      .o_m_err     (m_err),
      .o_err_count (err_count),
      .o_s_addr    (s_addr),
      .o_s_wdata   (s_wdata),
      .o_s_we      (s_we),
      .o_s_re      (s_re),
      .i_s_rdata   (s_rdata),
      .i_s_ready   (s_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]   rdata;
      logic          err;
      logic [NS-1:0] wem;
      logic [NS-1:0] rem;
      int            cyc;
      logic [31:0]   addr;
      logic [31:0]   wdata;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int          errs  = 0;
   int          scnt  = 0;
   logic [15:0] bases [NS] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Monitor: strobe checks each cycle, response popped from scoreboard on m_ready
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            scnt = 0;
         end else begin
            if ((s_we | s_re) != '0) begin
               if (sb.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL strobe_unexpected: got we=%b re=%b expected none", s_we, s_re);
               end else begin
                  chk("s_we", 64'(s_we), 64'(sb[0].wem));
                  chk("s_re", 64'(s_re), 64'(sb[0].rem));
                  chk("s_addr", 64'(s_addr), 64'(sb[0].addr));
                  chk("s_wdata", 64'(s_wdata), 64'(sb[0].wdata));
               end
               scnt++;
            end else begin
               chk("s_addr_idle", 64'(s_addr), 64'd0);
               chk("s_wdata_idle", 64'(s_wdata), 64'd0);
            end
            if (m_ready) begin
               if (sb.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL m_ready_unexpected: got 1 expected 0");
               end else begin
                  e = sb.pop_front();
                  chk("m_rdata", 64'(m_rdata), 64'(e.rdata));
                  chk("m_err", 64'(m_err), 64'(e.err));
                  chk("strobe_cycles", 64'(scnt), 64'(e.cyc));
               end
               scnt = 0;
            end else begin
               chk("m_err_idle", 64'(m_err), 64'd0);
               chk("m_rdata_idle", 64'(m_rdata), 64'd0);
            end
         end
      end
   end

   // One master transaction; d = strobe cycle in which the slave answers
   task automatic run_txn(input logic we, input logic re, input logic [31:0] addr,
                          input logic [31:0] wdata, input int d,
                          input bit scramble, input bit hold);
      exp_t e;
      int   idx = -1;
      int   edges = 0;
      int   lat;
      bit   got = 0;
      for (int i = 0; i < NS; i++) begin
         if (idx < 0 && addr[31:16] == bases[i]) idx = i;
         s_rdata[i*32 +: 32] = $urandom;
      end
      e.wem = '0; e.rem = '0; e.addr = addr; e.wdata = wdata;
      if (idx < 0) begin
         e.err = 1'b1; e.rdata = '0; e.cyc = 0; lat = 1;
      end else begin
         e.err = (d > TO);
         e.cyc = (d > TO) ? TO : d;
         if (we) e.wem[idx] = 1'b1; else e.rem[idx] = 1'b1;
         e.rdata = (e.err || we) ? 32'd0 : s_rdata[idx*32 +: 32];
         lat = e.cyc + 1;
      end
      if (e.err) errs++;
      sb.push_back(e);
      m_we = we; m_re = re; m_addr = addr; m_wdata = wdata; s_ready = '0;
      while (!got && edges < 60) begin
         @(posedge clk); #1;
         edges++;
         if (m_ready) begin
            got = 1;
         end else if (idx >= 0) begin
            s_ready = NS'($urandom);
            s_ready[idx] = (edges == d);
            if (scramble) begin
               m_addr = $urandom; m_wdata = $urandom;
               m_we = 1'($urandom); m_re = 1'($urandom);
            end
         end
      end
      if (!got) begin
         tests++; fails++;
         $display("FAIL m_ready_timeout: got no m_ready expected one within 60 cycles");
      end
      chk("latency", 64'(edges), 64'(lat));
      s_ready = '0;
      if (!hold) begin
         m_we = 1'b0; m_re = 1'b0;
      end
      @(posedge clk); #1;
      chk("err_count", 64'(err_count), 64'((errs > 255) ? 255 : errs));
   endtask

   initial begin
      logic        we, re;
      logic [31:0] a;
      #2;
      chk("rst_s_we", 64'(s_we), 64'd0);
      chk("rst_s_re", 64'(s_re), 64'd0);
      chk("rst_m_ready", 64'(m_ready), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      chk("rst_s_addr", 64'(s_addr), 64'd0);
      #11 rst = 1'b1;
      @(posedge clk); #1;

      run_txn(1'b0, 1'b1, 32'h2000_0010, 32'h0, 1, 0, 0);
      run_txn(1'b1, 1'b0, 32'h1000_0004, 32'hA5A5_A5A5, 3, 0, 0);
      run_txn(1'b0, 1'b1, 32'h5000_0000, 32'h0, 1, 0, 0);
      run_txn(1'b1, 1'b0, 32'h3000_0000, 32'h1234_5678, 99, 0, 0);
      run_txn(1'b1, 1'b0, 32'h3000_0000, 32'h8765_4321, TO, 0, 0);
      run_txn(1'b1, 1'b1, 32'h4000_0000, 32'h0BAD_F00D, 4, 1, 0);

      // Reset in the middle of an access to slave 2
      begin
         exp_t e;
         e.rdata = '0; e.err = 1'b0; e.wem = '0; e.rem = 4'b0100; e.cyc = 0;
         e.addr = 32'h3000_0040; e.wdata = 32'h0;
         sb.push_back(e);
         m_we = 1'b0; m_re = 1'b1; m_addr = 32'h3000_0040; m_wdata = 32'h0;
         repeat (3) begin @(posedge clk); #1; end
         #2 rst = 1'b0;
         #1;
         chk("abort_s_re", 64'(s_re), 64'd0);
         chk("abort_s_we", 64'(s_we), 64'd0);
         chk("abort_s_addr", 64'(s_addr), 64'd0);
         chk("abort_m_ready", 64'(m_ready), 64'd0);
         chk("abort_err_count", 64'(err_count), 64'd0);
         sb.delete();
         errs = 0;
         m_re = 1'b0;
         @(posedge clk); #1;
         chk("abort_no_m_ready", 64'(m_ready), 64'd0);
         #2 rst = 1'b1;
         @(posedge clk); #1;
      end

      // Held request after RESP starts a second transaction
      run_txn(1'b1, 1'b0, 32'h2000_0020, 32'hFEED_0001, 2, 0, 1);
      run_txn(1'b1, 1'b0, 32'h2000_0020, 32'hFEED_0001, 1, 0, 0);

      for (int n = 0; n < 150; n++) begin
         we = 1'($urandom);
         re = we ? 1'($urandom) : 1'b1;
         a  = $urandom;
         if ($urandom_range(0, 9) < 8) a[31:16] = bases[$urandom_range(0, NS-1)];
         run_txn(we, re, a, $urandom, $urandom_range(1, TO + 4), 1, 0);
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end

      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         tests++; fails++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion expected finish before 1ms");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
